// File: rtl/program_loader.sv
// Frames a received byte stream into 32-bit little-endian words and writes them
// to program memory from address 0, holding the core in reset while loading.
module program_loader #(
  parameter int MEMORY_DEPTH   = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start_i,
  input  logic [7:0]            Byte_i,
  input  logic                  Byte_Valid_i,
  output logic                  Write_Enable_o,
  output logic [DATA_WIDTH-1:0] Write_Address_o,
  output logic [DATA_WIDTH-1:0] Write_Data_o,
  output logic                  Busy_o,
  output logic                  Done_o,
  output logic                  Error_o,
  output logic                  Cpu_Reset_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] DEPTH_WORDS = 16'(MEMORY_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state_reg, state_next;
  logic [15:0]           len_reg, len_next;
  logic [15:0]           word_idx_reg, word_idx_next;
  logic [1:0]            byte_idx_reg, byte_idx_next;
  logic [7:0]            sum_reg, sum_next;
  logic [TW-1:0]         tmo_reg, tmo_next;
  logic [23:0]           asm_reg, asm_next;
  logic                  we_reg, we_next;
  logic [DATA_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;

  logic        active;
  logic        byte_take;
  logic        data_take;
  logic [7:0]  sum_acc;
  logic [15:0] len_full;
  logic [31:0] word_full;

  assign active    = (state_reg == S_LEN_LO) || (state_reg == S_LEN_HI) ||
                     (state_reg == S_DATA)   || (state_reg == S_CHECK);
  assign byte_take = active && Byte_Valid_i;
  assign data_take = byte_take && (state_reg == S_DATA);
  assign sum_acc   = sum_reg + Byte_i;
  assign len_full  = {Byte_i, len_reg[7:0]};
  // The fourth byte is taken straight from the input so the word is written
  // without an extra staging cycle.
  assign word_full = {Byte_i, asm_reg};

  // Lower three byte lanes of the word under assembly, one lane per byte index.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      assign asm_next[gi*8 +: 8] =
        (data_take && (byte_idx_reg == 2'(gi))) ? Byte_i : asm_reg[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      len_reg      <= '0;
      word_idx_reg <= '0;
      byte_idx_reg <= '0;
      sum_reg      <= '0;
      tmo_reg      <= '0;
      asm_reg      <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      data_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      word_idx_reg <= word_idx_next;
      byte_idx_reg <= byte_idx_next;
      sum_reg      <= sum_next;
      tmo_reg      <= tmo_next;
      asm_reg      <= asm_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    word_idx_next = word_idx_reg;
    byte_idx_next = byte_idx_reg;
    sum_next      = sum_reg;
    tmo_next      = tmo_reg;
    we_next       = 1'b0;
    addr_next     = addr_reg;
    data_next     = data_reg;

    if (active) begin
      if (Byte_Valid_i) begin
        sum_next = sum_acc;
        tmo_next = '0;
      end else if (tmo_reg == TIMEOUT_LAST) begin
        state_next = S_ERROR;
      end else begin
        tmo_next = tmo_reg + TW'(1);
      end
    end

    case (state_reg)
      S_IDLE, S_DONE, S_ERROR: begin
        // Start is only honoured outside a frame; a byte in the same cycle is dropped.
        if (Start_i) begin
          state_next    = S_LEN_LO;
          word_idx_next = '0;
          byte_idx_next = '0;
          sum_next      = '0;
          tmo_next      = '0;
        end
      end
      S_LEN_LO: begin
        if (byte_take) begin
          len_next   = {len_reg[15:8], Byte_i};
          state_next = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (byte_take) begin
          len_next = len_full;
          if (len_full > DEPTH_WORDS) begin
            state_next = S_ERROR;
          end else if (len_full == 16'd0) begin
            state_next = S_CHECK;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (byte_take) begin
          byte_idx_next = byte_idx_reg + 2'd1;
          if (byte_idx_reg == 2'd3) begin
            we_next       = 1'b1;
            addr_next     = DATA_WIDTH'({word_idx_reg, 2'b00});
            data_next     = DATA_WIDTH'(word_full);
            word_idx_next = word_idx_reg + 16'd1;
            if (word_idx_reg == len_reg - 16'd1) begin
              state_next = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        if (byte_take) begin
          state_next = (sum_acc == 8'd0) ? S_DONE : S_ERROR;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign Write_Enable_o  = we_reg;
  assign Write_Address_o = addr_reg;
  assign Write_Data_o    = data_reg;
  assign Busy_o          = active;
  assign Done_o          = (state_reg == S_DONE);
  assign Error_o         = (state_reg == S_ERROR);
  // The core stays in reset after a failed load so it never runs a partial image.
  assign Cpu_Reset_o     = active || (state_reg == S_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: framing, checksum, length limits,
// timeout, reset mid-frame and start-while-busy.
module tb_program_loader;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start_i;
  logic [7:0]  Byte_i;
  logic        Byte_Valid_i;
  logic        Write_Enable_o;
  logic [31:0] Write_Address_o;
  logic [31:0] Write_Data_o;
  logic        Busy_o;
  logic        Done_o;
  logic        Error_o;
  logic        Cpu_Reset_o;

  always #5 clk = ~clk;

  program_loader #(
    .MEMORY_DEPTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Start_i(Start_i),
    .Byte_i(Byte_i),
    .Byte_Valid_i(Byte_Valid_i),
    .Write_Enable_o(Write_Enable_o),
    .Write_Address_o(Write_Address_o),
    .Write_Data_o(Write_Data_o),
    .Busy_o(Busy_o),
    .Done_o(Done_o),
    .Error_o(Error_o),
    .Cpu_Reset_o(Cpu_Reset_o)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [31:0] wr_addr [0:255];
  logic [31:0] wr_data [0:255];
  int wr_count = 0;

  always @(negedge clk) begin
    if (Write_Enable_o === 1'b1) begin
      if (wr_count < 256) begin
        wr_addr[wr_count] = Write_Address_o;
        wr_data[wr_count] = Write_Data_o;
      end
      wr_count++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    Byte_i = b;
    Byte_Valid_i = 1'b1;
    tick();
    Byte_Valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    Start_i = 1'b1;
    tick();
    Start_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    $display("check reset-state outputs: %s", tag);
    check({tag, "_we"},   {31'd0, Write_Enable_o}, 32'd0);
    check({tag, "_addr"}, Write_Address_o, 32'd0);
    check({tag, "_data"}, Write_Data_o, 32'd0);
    check({tag, "_busy"}, {31'd0, Busy_o}, 32'd0);
    check({tag, "_done"}, {31'd0, Done_o}, 32'd0);
    check({tag, "_err"},  {31'd0, Error_o}, 32'd0);
    check({tag, "_cpu"},  {31'd0, Cpu_Reset_o}, 32'd0);
  endtask

  int base;

  initial begin
    reset = 1'b1;
    Start_i = 1'b0;
    Byte_i = 8'h00;
    Byte_Valid_i = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // Frame 1: N=2, good checksum 0x67 (sum of other bytes is 0x99).
    base = wr_count;
    pulse_start();
    $display("frame1 good: start");
    check("f1_busy_rise", {31'd0, Busy_o}, 32'd1);
    check("f1_cpu_rise", {31'd0, Cpu_Reset_o}, 32'd1);
    send(8'h02); send(8'h00);
    send(8'h93); send(8'h00); send(8'h50); send(8'h00);
    check("f1_w0_we", {31'd0, Write_Enable_o}, 32'd1);
    check("f1_w0_addr", Write_Address_o, 32'h0);
    check("f1_w0_data", Write_Data_o, 32'h00500093);
    send(8'h13);
    check("f1_we_one_cycle", {31'd0, Write_Enable_o}, 32'd0);
    check("f1_w0_addr_hold", Write_Address_o, 32'h0);
    send(8'h01); send(8'hA0); send(8'h00);
    check("f1_w1_we", {31'd0, Write_Enable_o}, 32'd1);
    check("f1_w1_addr", Write_Address_o, 32'h4);
    check("f1_w1_data", Write_Data_o, 32'h00A00113);
    send(8'h67);
    $display("frame1 good: checksum sent");
    check("f1_we_low", {31'd0, Write_Enable_o}, 32'd0);
    check("f1_done", {31'd0, Done_o}, 32'd1);
    check("f1_err", {31'd0, Error_o}, 32'd0);
    check("f1_busy", {31'd0, Busy_o}, 32'd0);
    check("f1_cpu", {31'd0, Cpu_Reset_o}, 32'd0);
    check("f1_addr_hold", Write_Address_o, 32'h4);
    check("f1_nwrites", 32'(wr_count - base), 32'd2);
    check("f1_log0_data", wr_data[base], 32'h00500093);
    check("f1_log1_addr", wr_addr[base + 1], 32'h4);

    // Frame 2: same frame with checksum byte +1.
    base = wr_count;
    pulse_start();
    $display("frame2 bad checksum: start");
    check("f2_done_cleared", {31'd0, Done_o}, 32'd0);
    send(8'h02); send(8'h00);
    send(8'h93); send(8'h00); send(8'h50); send(8'h00);
    send(8'h13); send(8'h01); send(8'hA0); send(8'h00);
    send(8'h68);
    check("f2_err", {31'd0, Error_o}, 32'd1);
    check("f2_done", {31'd0, Done_o}, 32'd0);
    check("f2_cpu", {31'd0, Cpu_Reset_o}, 32'd1);
    check("f2_busy", {31'd0, Busy_o}, 32'd0);
    check("f2_nwrites", 32'(wr_count - base), 32'd2);
    check("f2_log1_data", wr_data[base + 1], 32'h00A00113);

    // Frame 3: LEN = 33 is one past capacity.
    base = wr_count;
    pulse_start();
    $display("frame3 oversize length: start");
    check("f3_err_cleared", {31'd0, Error_o}, 32'd0);
    send(8'h21);
    check("f3_err_before_hi", {31'd0, Error_o}, 32'd0);
    send(8'h00);
    check("f3_err", {31'd0, Error_o}, 32'd1);
    check("f3_busy", {31'd0, Busy_o}, 32'd0);
    check("f3_cpu", {31'd0, Cpu_Reset_o}, 32'd1);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check("f3_nwrites", 32'(wr_count - base), 32'd0);
    check("f3_err_held", {31'd0, Error_o}, 32'd1);

    // Frame 4: N=0, checksum 0x00.
    base = wr_count;
    pulse_start();
    $display("frame4 empty: start");
    send(8'h00); send(8'h00);
    check("f4_busy_in_check", {31'd0, Busy_o}, 32'd1);
    send(8'h00);
    check("f4_done", {31'd0, Done_o}, 32'd1);
    check("f4_err", {31'd0, Error_o}, 32'd0);
    check("f4_nwrites", 32'(wr_count - base), 32'd0);

    // Frame 5: N=32, word k bytes {k,40,80,C0}; sum 0x10 so checksum 0xF0.
    base = wr_count;
    pulse_start();
    $display("frame5 full depth: start");
    send(8'h20); send(8'h00);
    for (int k = 0; k < 32; k++) begin
      send(8'(k)); send(8'h40); send(8'h80); send(8'hC0);
    end
    send(8'hF0);
    check("f5_done", {31'd0, Done_o}, 32'd1);
    check("f5_err", {31'd0, Error_o}, 32'd0);
    check("f5_nwrites", 32'(wr_count - base), 32'd32);
    check("f5_first_data", wr_data[base], 32'hC0804000);
    check("f5_last_addr", wr_addr[base + 31], 32'h7C);
    check("f5_last_data", wr_data[base + 31], 32'hC080401F);
    check("f5_mid_addr", wr_addr[base + 17], 32'h44);
    check("f5_mid_data", wr_data[base + 17], 32'hC0804011);

    // Frame 6: stall after two data bytes; 16th idle cycle is terminal.
    base = wr_count;
    pulse_start();
    $display("frame6 timeout: start");
    send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    repeat (TO - 1) tick();
    check("f6_err_15idle", {31'd0, Error_o}, 32'd0);
    check("f6_busy_15idle", {31'd0, Busy_o}, 32'd1);
    tick();
    check("f6_err_16idle", {31'd0, Error_o}, 32'd1);
    check("f6_busy_16idle", {31'd0, Busy_o}, 32'd0);
    check("f6_cpu_16idle", {31'd0, Cpu_Reset_o}, 32'd1);
    check("f6_nwrites", 32'(wr_count - base), 32'd0);

    // Frame 7: recovery frame with a 15-cycle gap inside the word (just under timeout).
    base = wr_count;
    pulse_start();
    $display("frame7 recovery: start");
    send(8'h01); send(8'h00); send(8'hEF); send(8'hBE);
    repeat (TO - 1) tick();
    send(8'hAD); send(8'hDE);
    check("f7_w_data", Write_Data_o, 32'hDEADBEEF);
    send(8'hC7);
    check("f7_done", {31'd0, Done_o}, 32'd1);
    check("f7_err", {31'd0, Error_o}, 32'd0);
    check("f7_nwrites", 32'(wr_count - base), 32'd1);
    check("f7_log_addr", wr_addr[base], 32'h0);

    // Frame 8: Start pulsed mid-frame must not restart it.
    base = wr_count;
    pulse_start();
    $display("frame8 start while busy: start");
    send(8'h02); send(8'h00);
    send(8'h93); send(8'h00); send(8'h50); send(8'h00);
    pulse_start();
    check("f8_busy_after_start", {31'd0, Busy_o}, 32'd1);
    send(8'h13); send(8'h01); send(8'hA0); send(8'h00);
    send(8'h67);
    check("f8_done", {31'd0, Done_o}, 32'd1);
    check("f8_err", {31'd0, Error_o}, 32'd0);
    check("f8_nwrites", 32'(wr_count - base), 32'd2);
    check("f8_log1_data", wr_data[base + 1], 32'h00A00113);

    // Frame 9: reset after word 0 is written.
    pulse_start();
    $display("frame9 reset mid-frame: start");
    send(8'h02); send(8'h00);
    send(8'h93); send(8'h00); send(8'h50); send(8'h00);
    send(8'h13);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("f9_rst");
    base = wr_count;
    send(8'h01); send(8'hA0); send(8'h00); send(8'h67);
    tick();
    check("f9_nwrites_after", 32'(wr_count - base), 32'd0);
    check("f9_busy_after", {31'd0, Busy_o}, 32'd0);
    check("f9_done_after", {31'd0, Done_o}, 32'd0);

    // Frame 10: Start and a byte in the same IDLE cycle; the byte is dropped.
    base = wr_count;
    Start_i = 1'b1;
    Byte_i = 8'h05;
    Byte_Valid_i = 1'b1;
    tick();
    Start_i = 1'b0;
    Byte_Valid_i = 1'b0;
    $display("frame10 start with byte: start");
    check("f10_busy", {31'd0, Busy_o}, 32'd1);
    send(8'h00); send(8'h00); send(8'h00);
    check("f10_done", {31'd0, Done_o}, 32'd1);
    check("f10_nwrites", 32'(wr_count - base), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Sequential writer for the writable program memory. It accepts a byte stream (from the serial receiver), frames it into 32-bit little-endian instruction words and issues single-cycle write strobes at word-aligned byte addresses starting at 0. It holds the core in reset while a load is in progress and reports completion or error. It sits between the byte receiver and the write port of the instruction memory; the core's fetch path reads the same memory.

## Interface
- MEMORY_DEPTH, 32, capacity in words; largest accepted word count.
- DATA_WIDTH, 32, width of write address and write data.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes inside a frame before the frame is aborted.
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high.
- Start_i  input  1  one-cycle pulse; arms a new load.
- Byte_i  input  8  received byte.
- Byte_Valid_i  input  1  one-cycle strobe qualifying Byte_i.
- Write_Enable_o  output  1  one-cycle write strobe to program memory.
- Write_Address_o  output  DATA_WIDTH  byte address, always a multiple of 4.
- Write_Data_o  output  DATA_WIDTH  instruction word.
- Busy_o  output  1  high while a frame is in progress.
- Done_o  output  1  frame loaded and checksum good; level.
- Error_o  output  1  frame aborted or bad; level.
- Cpu_Reset_o  output  1  holds the core in reset.

## Operation
- Frame format: LEN_LO, LEN_HI (16-bit word count N), then 4·N data bytes (each word LSB first), then 1 checksum byte. The 8-bit sum of all 4·N+3 frame bytes must be 0 mod 256.
- States:
  - IDLE: Byte_Valid_i is ignored. Start_i moves to LEN_LO, clears Done_o and Error_o, sets Busy_o and Cpu_Reset_o, and zeroes the word index, byte index, checksum and timeout counter.
  - LEN_LO: a byte moves to LEN_HI.
  - LEN_HI: a byte completes N. If N > MEMORY_DEPTH, go to ERROR. If N = 0, go to CHECK. Otherwise go to DATA.
  - DATA: bytes are shifted into a 32-bit assembly register, LSB first. On the 4th byte of a word, the word is written (see Timing). After word N-1 is written, go to CHECK.
  - CHECK: a byte is added to the checksum. A zero result goes to DONE; a nonzero result goes to ERROR.
  - DONE: Done_o=1, Busy_o=0, Cpu_Reset_o=0. Start_i begins a new frame.
  - ERROR: Error_o=1, Busy_o=0, Cpu_Reset_o stays 1. Start_i begins a new frame.
- Checksum accumulates every accepted byte from LEN_LO through CHECK, modulo 256.
- Timeout: in LEN_LO, LEN_HI, DATA or CHECK, the counter increments on each cycle without Byte_Valid_i and clears on a byte. Reaching TIMEOUT_CYCLES goes to ERROR.
- Start_i while Busy_o=1 is ignored; the current frame continues.
- Words already written before an ERROR stay in memory. Recovery is by a new frame.
- Write_Address_o = word_index·4, zero-extended to DATA_WIDTH. Bits [1:0] are always 0.

## Timing
- Reset values: Write_Enable_o=0, Write_Address_o=0, Write_Data_o=0, Busy_o=0, Done_o=0, Error_o=0, Cpu_Reset_o=0, state IDLE.
- Reset asserted mid-frame returns to IDLE the next edge and drops Cpu_Reset_o. No further write strobes are issued.
- Busy_o and Cpu_Reset_o rise the cycle after Start_i is sampled.
- Write latency: Write_Enable_o is high exactly one cycle, the cycle after the 4th byte of a word is sampled. Address and data are valid in that same cycle and hold until the next write.
- A byte may arrive every cycle. The write strobe for word k overlaps acceptance of the first byte of word k+1 with no loss.
- Done_o or Error_o rises the cycle after the deciding byte (checksum byte, LEN_HI, or the timeout-terminal cycle). Both are levels, held until Start_i or reset.
- Start_i and Byte_Valid_i in the same IDLE cycle: Start_i is taken and the byte is dropped.

## Test plan
- N=2, words 0x00500093, 0x00A00113, correct checksum, one byte per cycle -> two strobes at addresses 0x0 and 0x4 with those data, Done_o=1, Cpu_Reset_o=0, Busy_o=0.
- Same frame with checksum byte +1 -> both writes still occur, Error_o=1, Done_o=0, Cpu_Reset_o=1.
- LEN = MEMORY_DEPTH+1 (0x0021 with default 32) -> Error_o=1 the cycle after LEN_HI, no write strobe.
- N=0, checksum byte 0x00 -> no writes, Done_o=1. Also N=32 full frame -> last write at 0x7C, Done_o=1.
- TIMEOUT_CYCLES=16, frame stalls after 2 data bytes -> Error_o=1 on the 16th idle cycle, no strobe. A following Start_i and valid frame -> Done_o=1.
- Reset pulsed after word 0 is written -> all outputs return to reset values. Later bytes are ignored until Start_i. Start_i pulsed while busy -> no effect on the current frame.
